// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
//   Shared definitions for the round-robin arbiter family.
//   - MAX_CH      : largest channel count any arbiter in this family supports
//   - arb_state_t : burst-lock state (idle / locked to one channel)
//   - rr_pick     : behavioural round-robin pick, returns a one-hot grant
// ---------------------------------------------------------------------------
package rr_arb_pkg;

    localparam int MAX_CH   = 16;
    localparam int MAX_CH_W = $clog2(MAX_CH);

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Searches ptr, ptr+1 ... n_ch-1, 0 ... ptr-1 and grants the first requester.
    // Bits at or above n_ch are ignored, so narrower arbiters can share it.
    function automatic logic [MAX_CH-1:0] rr_pick(
        input logic [MAX_CH-1:0] req,
        input int unsigned       ptr,
        input int unsigned       n_ch = MAX_CH
    );
        logic [MAX_CH-1:0]   gnt;
        logic [MAX_CH_W-1:0] idx;
        logic                found;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (i < n_ch) begin
                idx = MAX_CH_W'((ptr + i) % n_ch);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_pick_logic.sv
// ---------------------------------------------------------------------------
// rr_pick_logic
//   Combinational round-robin picker: rotate the request vector so that the
//   pointer channel sits at bit 0, priority-encode the lowest set bit, then
//   rotate the index back into channel numbering.
// Ports
//   req        in   N_CH   request vector
//   ptr        in   CH_W   highest-priority channel this cycle (< N_CH)
//   grant      out  N_CH   one-hot grant (all zeros when no request)
//   grant_idx  out  CH_W   index of the granted channel
//   grant_any  out  1      at least one request present
// ---------------------------------------------------------------------------
module rr_pick_logic #(
    parameter int N_CH = 8,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            grant_any
);

    localparam logic [CH_W:0] NCH_EXT = (CH_W+1)'(N_CH);

    logic [2*N_CH-1:0] req_dbl;
    logic [N_CH-1:0]   req_rot;
    logic [CH_W-1:0]   rot_idx;
    logic [CH_W:0]     idx_sum;

    // Doubling the vector lets a plain part-select act as a rotate right by ptr.
    assign req_dbl   = {req, req};
    assign req_rot   = req_dbl[ptr +: N_CH];
    assign grant_any = |req;

    // Lowest set bit of the rotated vector wins; scanning downward leaves it last.
    always_comb begin
        rot_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) rot_idx = CH_W'(i);
        end
    end

    // Undo the rotation: (rot_idx + ptr) mod N_CH, both operands already < N_CH.
    always_comb begin
        idx_sum = {1'b0, rot_idx} + {1'b0, ptr};
        if (idx_sum >= NCH_EXT) begin
            grant_idx = CH_W'(idx_sum - NCH_EXT);
        end else begin
            grant_idx = idx_sum[CH_W-1:0];
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant[i] = grant_any && (grant_idx == CH_W'(i));
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// ---------------------------------------------------------------------------
// rr_arb_mux
//   N-channel round-robin selector with a one-entry registered output stage.
//   A word granted at a clock edge appears on out_data/out_ch after that edge;
//   the stage refills in the same cycle it drains, so throughput is one word
//   per cycle.
// Optional feature (macro RR_ARB_MUX_LOCK_EN): burst locking. A channel that
//   is granted with in_last low keeps exclusive ownership until it sends a
//   word with in_last high.
// Ports
//   clk        in   1           rising-edge clock
//   rst_n      in   1           synchronous reset, active-low
//   in_valid   in   N_CH        per-channel request
//   in_data    in   N_CH*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   in_ready   out  N_CH        one-hot grant for the channel accepted this cycle
//   out_valid  out  1           output register holds a word
//   out_data   out  WIDTH       registered data
//   out_ch     out  CH_W        channel index of out_data
//   out_ready  in   1           downstream accept
//   in_last    in   N_CH        (RR_ARB_MUX_LOCK_EN only) final word of a burst
// ---------------------------------------------------------------------------
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int WIDTH = 16,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
`ifdef RR_ARB_MUX_LOCK_EN
    ,
    input  logic [N_CH-1:0]       in_last
`endif
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] ptr_inc;
    logic            ptr_adv;
    logic            load;
    logic            take;
    logic [N_CH-1:0] pick_req;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] grant_idx;
    logic            grant_any;

    // The stage can accept a new word when empty or being drained this cycle.
    assign load = ~out_valid | out_ready;
    // rst_n is folded in so no channel sees a handshake during the reset cycle.
    assign take = rst_n & load & grant_any;
    assign in_ready = take ? grant : '0;

    // Pointer moves one past the winner, wrapping after the last channel.
    assign ptr_inc = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

    rr_pick_logic #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .req       (pick_req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

`ifdef RR_ARB_MUX_LOCK_EN
    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [CH_W-1:0] lch;
    logic [CH_W-1:0] lch_nxt;

    // Lock state register: which channel (if any) currently owns the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            lch   <= '0;
        end else begin
            state <= state_nxt;
            lch   <= lch_nxt;
        end
    end

    // A grant without in_last opens a burst; the owner's in_last grant closes it.
    always_comb begin
        state_nxt = state;
        lch_nxt   = lch;
        case (state)
            ARB_IDLE: begin
                if (take && !in_last[grant_idx]) begin
                    state_nxt = ARB_LOCKED;
                    lch_nxt   = grant_idx;
                end
            end
            ARB_LOCKED: begin
                if (take && in_last[lch]) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // While locked only the owner may request. The pointer only advances on a
    // burst-ending word, which in the locked state is always the owner itself.
    always_comb begin
        pick_req = in_valid;
        if (state == ARB_LOCKED) begin
            for (int i = 0; i < N_CH; i++) begin
                pick_req[i] = in_valid[i] && (lch == CH_W'(i));
            end
        end
        ptr_adv = take && in_last[grant_idx];
    end
`else
    // Without locking every grant is a complete one-word burst.
    always_comb begin
        pick_req = in_valid;
        ptr_adv  = take;
    end
`endif

    // Output stage and pointer. A load cycle with no winner leaves a bubble;
    // a stalled stage (load low) holds everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
                out_ch    <= grant_idx;
            end else if (load) begin
                out_valid <= 1'b0;
            end
            if (ptr_adv) ptr <= ptr_inc;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_mux
//   Directed bench for rr_arb_mux (N_CH=8, WIDTH=16). Each step drives the
//   inputs just after a rising edge, checks the combinational grant, then
//   checks the registered output just after the next rising edge.
//   Burst-lock steps are included when RR_ARB_MUX_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_rr_arb_mux;

    localparam int N_CH  = 8;
    localparam int WIDTH = 16;
    localparam int CH_W  = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;
    logic                  out_ready;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [N_CH-1:0]       in_last;
`endif

    logic [WIDTH-1:0] chData [N_CH];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Pack the per-channel words onto the flat data bus.
    always_comb begin
        in_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            in_data[k*WIDTH +: WIDTH] = chData[k];
        end
    end

    rr_arb_mux #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
`ifdef RR_ARB_MUX_LOCK_EN
        ,
        .in_last   (in_last)
`endif
    );

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the inputs and let the combinational grant settle.
    task automatic applyStimulus(input logic r, input logic [N_CH-1:0] v, input logic ordy);
        rst_n     = r;
        in_valid  = v;
        out_ready = ordy;
        #1;
    endtask

    // One clock step: check in_ready before the edge, out_* after it.
    // Payload is skipped on bubbles, where only out_valid is defined.
    task automatic stepCheck(input string tag, input logic r, input logic [N_CH-1:0] v,
                             input logic ordy, input logic [N_CH-1:0] expReady,
                             input logic expValid, input logic [CH_W-1:0] expCh,
                             input logic [WIDTH-1:0] expData, input logic chkPayload);
        applyStimulus(r, v, ordy);
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(expReady));
        @(posedge clk);
        #1;
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(expValid));
        if (chkPayload) begin
            checkOutput({tag, ".out_ch"}, 32'(out_ch), 32'(expCh));
            checkOutput({tag, ".out_data"}, 32'(out_data), 32'(expData));
        end
    endtask

    initial begin
        for (int k = 0; k < N_CH; k++) chData[k] = 16'hA000 + 16'(k);
        rst_n     = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
        in_last   = '1;
`endif
        @(posedge clk);
        #1;

        // Reset held two cycles with every channel requesting.
        stepCheck("rst0", 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b1);
        stepCheck("rst1", 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b1);

        // All channels valid: 0..7 then 0 again, one word per cycle.
        for (int i = 0; i <= N_CH; i++) begin
            stepCheck($sformatf("rr%0d", i), 1'b1, 8'hFF, 1'b1, 8'(1 << (i % N_CH)),
                      1'b1, 3'(i % N_CH), 16'hA000 + 16'(i % N_CH), 1'b1);
        end

        // Bubble, then ch5 alone, then ch2+ch6 (ptr=6 gives 6, then wrap to 2).
        stepCheck("bubble", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0);
        stepCheck("ch5",    1'b1, 8'h20, 1'b1, 8'h20, 1'b1, 3'd5, 16'hA005, 1'b1);
        stepCheck("ch6",    1'b1, 8'h44, 1'b1, 8'h40, 1'b1, 3'd6, 16'hA006, 1'b1);
        stepCheck("wrap2",  1'b1, 8'h44, 1'b1, 8'h04, 1'b1, 3'd2, 16'hA002, 1'b1);

        // Stall three cycles: output held, no grant; then release in order from ptr=3.
        for (int i = 0; i < 3; i++) begin
            stepCheck($sformatf("stall%0d", i), 1'b1, 8'hFF, 1'b0, 8'h00,
                      1'b1, 3'd2, 16'hA002, 1'b1);
        end
        stepCheck("rel3", 1'b1, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 16'hA003, 1'b1);
        stepCheck("rel4", 1'b1, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 16'hA004, 1'b1);
        stepCheck("rel5", 1'b1, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 16'hA005, 1'b1);

        // Empty stage accepts even with out_ready low; full stage then stalls.
        stepCheck("drain",     1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0);
        stepCheck("emptyFill", 1'b1, 8'h02, 1'b0, 8'h02, 1'b1, 3'd1, 16'hA001, 1'b1);
        stepCheck("fullStall", 1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 3'd1, 16'hA001, 1'b1);
        stepCheck("drain2",    1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0);

        // Reset in the middle of traffic: word discarded, ptr back to 0.
        stepCheck("midGo",   1'b1, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 16'hA002, 1'b1);
        stepCheck("midRst",  1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b1);
        stepCheck("postRst", 1'b1, 8'h18, 1'b1, 8'h08, 1'b1, 3'd3, 16'hA003, 1'b1);

`ifdef RR_ARB_MUX_LOCK_EN
        // ch3 three-word burst while ch4 waits: 3,3,3 then 4.
        stepCheck("lkRst0", 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b1);
        chData[3] = 16'h3001;
        in_last   = 8'hF7;
        stepCheck("burst1", 1'b1, 8'h18, 1'b1, 8'h08, 1'b1, 3'd3, 16'h3001, 1'b1);
        chData[3] = 16'h3002;
        stepCheck("burst2", 1'b1, 8'h18, 1'b1, 8'h08, 1'b1, 3'd3, 16'h3002, 1'b1);
        chData[3] = 16'h3003;
        in_last   = 8'hFF;
        stepCheck("burst3", 1'b1, 8'h18, 1'b1, 8'h08, 1'b1, 3'd3, 16'h3003, 1'b1);
        chData[3] = 16'hA003;
        stepCheck("after",  1'b1, 8'h18, 1'b1, 8'h10, 1'b1, 3'd4, 16'hA004, 1'b1);

        // Lock onto ch2 (ptr=5), owner drops valid -> bubble, then reset mid-burst.
        in_last = 8'h00;
        stepCheck("lk2a",   1'b1, 8'h0C, 1'b1, 8'h04, 1'b1, 3'd2, 16'hA002, 1'b1);
        stepCheck("lk2b",   1'b1, 8'h0C, 1'b1, 8'h04, 1'b1, 3'd2, 16'hA002, 1'b1);
        stepCheck("lkBub",  1'b1, 8'h08, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b0);
        stepCheck("lkRst",  1'b0, 8'h08, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b1);
        in_last = 8'hFF;
        stepCheck("lkFree", 1'b1, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 16'hA003, 1'b1);
        stepCheck("lkRst2", 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 1'b1);
        stepCheck("lkPtr0", 1'b1, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 16'hA000, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
